digit_sequence_reader: RTL and testbench

Reads back a stored digit sequence from the game's sequence RAM, shows each digit on the random-number display for a fixed pacing interval, then collects the player's keypad entries and compares each one with the stored digit. It sits between the game controller and the sequence RAM, on the read side of the digit sequencer that writes the RAM. It reports pass/fail to the controller and drives the random-number and player display digits.

---
 rtl/digit_sequence_reader.sv | 121 ++++++++++++
 tb/tb_digit_sequence_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_sequence_reader.sv
// digit_sequence_reader: plays a stored digit sequence from RAM, then checks the player's keypad entries against it.
module digit_sequence_reader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seq_start,
  input  logic [ADDR_WIDTH-1:0] seq_len,
  input  logic                  show_pulse,
  input  logic [3:0]            player_digit,
  input  logic                  player_enter,
  input  logic                  timeout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [3:0]            ram_rd_data,
  output logic [3:0]            disp_digit,
  output logic [3:0]            echo_digit,
  output logic                  busy,
  output logic                  done,
  output logic                  seq_pass,
  output logic                  seq_fail,
  output logic [ADDR_WIDTH-1:0] fail_index
);
  typedef enum logic [2:0] {IDLE, SHOW_RD, SHOW_HOLD, IN_RD, IN_WAIT, RESULT} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] idx, len;
  logic [3:0] exp_digit;
  logic rw, last;
  assign last = idx == len - 1'b1;
  // RAM data is sampled on the second edge after the address changes (rw counts the first)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      rw <= 1'b0;
      exp_digit <= '0;
      ram_addr <= '0;
      disp_digit <= 4'hF;
      echo_digit <= 4'hF;
      busy <= 1'b0;
      done <= 1'b0;
      seq_pass <= 1'b0;
      seq_fail <= 1'b0;
      fail_index <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (seq_start) begin
          seq_fail <= 1'b0;
          fail_index <= '0;
          len <= seq_len;
          idx <= '0;
          ram_addr <= '0;
          rw <= 1'b0;
          busy <= 1'b1;
          seq_pass <= seq_len == '0;
          done <= seq_len == '0;
          state <= seq_len == '0 ? RESULT : SHOW_RD;
        end
        SHOW_RD: begin
          rw <= ~rw;
          if (rw) begin
            disp_digit <= ram_rd_data;
            state <= SHOW_HOLD;
          end
        end
        SHOW_HOLD: if (show_pulse) begin
          rw <= 1'b0;
          idx <= last ? '0 : idx + 1'b1;
          ram_addr <= last ? '0 : ram_addr + 1'b1;
          disp_digit <= last ? 4'hF : disp_digit;
          state <= last ? IN_RD : SHOW_RD;
        end
        IN_RD: begin
          if (timeout) begin
            seq_fail <= 1'b1;
            fail_index <= idx;
            done <= 1'b1;
            state <= RESULT;
          end else begin
            rw <= ~rw;
            if (rw) begin
              exp_digit <= ram_rd_data;
              state <= IN_WAIT;
            end
          end
        end
        IN_WAIT: begin
          if (timeout) begin
            seq_fail <= 1'b1;
            fail_index <= idx;
            done <= 1'b1;
            state <= RESULT;
          end else if (player_enter) begin
            echo_digit <= player_digit;
            if (player_digit != exp_digit) begin
              seq_fail <= 1'b1;
              fail_index <= idx;
              done <= 1'b1;
              state <= RESULT;
            end else if (last) begin
              seq_pass <= 1'b1;
              done <= 1'b1;
              state <= RESULT;
            end else begin
              idx <= idx + 1'b1;
              ram_addr <= ram_addr + 1'b1;
              rw <= 1'b0;
              state <= IN_RD;
            end
          end
        end
        RESULT: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_sequence_reader.sv
// tb_digit_sequence_reader: directed runs with expectations derived from the sequence contents and cycle timing.
module tb_digit_sequence_reader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic seq_start = 1'b0;
  logic [3:0] seq_len = '0;
  logic show_pulse = 1'b0;
  logic [3:0] player_digit = '0;
  logic player_enter = 1'b0;
  logic timeout = 1'b0;
  logic [3:0] ram_addr, ram_rd_data, disp_digit, echo_digit, fail_index;
  logic busy, done, seq_pass, seq_fail;
  logic [3:0] mem [16];
  logic [3:0] keys [16];
  logic [3:0] addr_d = '0;
  logic [3:0] exp_addr = '0, exp_disp = 4'hF, exp_echo = 4'hF, exp_fidx = '0;
  logic exp_busy = 1'b0, exp_done = 1'b0, exp_pass = 1'b0, exp_fail = 1'b0;
  int checks = 0, errors = 0, done_cnt = 0;

  digit_sequence_reader #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .seq_start(seq_start), .seq_len(seq_len), .show_pulse(show_pulse),
    .player_digit(player_digit), .player_enter(player_enter), .timeout(timeout),
    .ram_addr(ram_addr), .ram_rd_data(ram_rd_data), .disp_digit(disp_digit), .echo_digit(echo_digit),
    .busy(busy), .done(done), .seq_pass(seq_pass), .seq_fail(seq_fail), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  // RAM data is usable at the second edge after the address changes
  always @(posedge clk) addr_d <= ram_addr;
  assign ram_rd_data = mem[addr_d];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ram_addr", ram_addr, exp_addr);
    chk("disp_digit", disp_digit, exp_disp);
    chk("echo_digit", echo_digit, exp_echo);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("seq_pass", seq_pass, exp_pass);
    chk("seq_fail", seq_fail, exp_fail);
    chk("fail_index", fail_index, exp_fidx);
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
  endtask

  task automatic set_reset_exp();
    exp_addr = '0; exp_disp = 4'hF; exp_echo = 4'hF; exp_fidx = '0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_pass = 1'b0; exp_fail = 1'b0;
  endtask

  task automatic start(input int n);
    seq_len = 4'(n);
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    exp_busy = 1'b1; exp_addr = '0; exp_pass = 1'b0; exp_fail = 1'b0; exp_fidx = '0;
    if (n == 0) begin
      exp_pass = 1'b1;
      exp_done = 1'b1;
      tick();
      exp_busy = 1'b0;
    end
  endtask

  // to_mode: 0 none, 1 timeout together with the first enter, 2 timeout during the first read
  task automatic run(input int n, input int nk, input bit noise, input int to_mode);
    done_cnt = 0;
    start(n);
    if (n == 0) return;
    for (int i = 0; i < n; i++) begin
      if (noise) begin seq_start = 1'b1; seq_len = '0; end
      tick();
      seq_start = 1'b0;
      tick();
      exp_disp = mem[i];
      if (noise) begin player_enter = 1'b1; player_digit = mem[i]; timeout = 1'b1; end
      tick();
      player_enter = 1'b0; timeout = 1'b0;
      show_pulse = 1'b1;
      tick();
      show_pulse = 1'b0;
      if (i < n - 1) exp_addr = 4'(i + 1);
      else begin exp_disp = 4'hF; exp_addr = '0; end
    end
    for (int k = 0; k < nk; k++) begin
      if (to_mode == 2) begin
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        exp_fail = 1'b1; exp_fidx = 4'(k); exp_done = 1'b1;
        tick();
        exp_busy = 1'b0;
        return;
      end
      if (noise) begin player_enter = 1'b1; player_digit = ~keys[k]; end
      tick();
      player_enter = 1'b0;
      tick();
      if (noise) begin
        show_pulse = 1'b1;
        tick();
        show_pulse = 1'b0;
      end
      player_digit = keys[k];
      player_enter = 1'b1;
      if (to_mode == 1) timeout = 1'b1;
      tick();
      player_enter = 1'b0; timeout = 1'b0;
      if (to_mode == 1) begin
        exp_fail = 1'b1; exp_fidx = 4'(k); exp_done = 1'b1;
      end else begin
        exp_echo = keys[k];
        if (keys[k] != mem[k]) begin exp_fail = 1'b1; exp_fidx = 4'(k); exp_done = 1'b1; end
        else if (k == n - 1) begin exp_pass = 1'b1; exp_done = 1'b1; end
        else exp_addr = 4'(k + 1);
      end
      if (exp_done) begin
        tick();
        exp_busy = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = '0; keys[i] = '0; end
    mem[0] = 4'd3; mem[1] = 4'd7; mem[2] = 4'd1;
    set_reset_exp();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    chk("lit_reset_disp", disp_digit, 4'hF);
    chk("lit_reset_busy", busy, 1'b0);
    tick();
    // abort during the show phase
    start(3);
    tick();
    tick();
    exp_disp = mem[0];
    @(posedge clk);
    #3 rst = 1'b0;
    set_reset_exp();
    #1;
    chk("lit_abort_busy", busy, 1'b0);
    chk("lit_abort_disp", disp_digit, 4'hF);
    chk("lit_abort_addr", ram_addr, 4'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk("lit_abort_no_done", done_cnt, 0);
    // full pass with ignored inputs sprinkled in
    keys[0] = 4'd3; keys[1] = 4'd7; keys[2] = 4'd1;
    run(3, 3, 1'b1, 0);
    tick();
    chk("lit_pass_flag", seq_pass, 1'b1);
    chk("lit_pass_echo", echo_digit, 4'd1);
    chk("lit_pass_fidx", fail_index, 4'd0);
    chk("lit_pass_done_once", done_cnt, 1);
    // mismatch on the second digit
    keys[1] = 4'd9;
    run(3, 3, 1'b0, 0);
    tick();
    chk("lit_mm_fail", seq_fail, 1'b1);
    chk("lit_mm_fidx", fail_index, 4'd1);
    chk("lit_mm_echo", echo_digit, 4'd9);
    chk("lit_mm_addr", ram_addr, 4'd1);
    // timeout beats a correct enter
    keys[1] = 4'd7;
    run(3, 3, 1'b0, 1);
    tick();
    chk("lit_race_fail", seq_fail, 1'b1);
    chk("lit_race_pass", seq_pass, 1'b0);
    chk("lit_race_fidx", fail_index, 4'd0);
    run(3, 3, 1'b0, 2);
    tick();
    // zero-length run
    run(0, 0, 1'b0, 0);
    tick();
    chk("lit_len0_pass", seq_pass, 1'b1);
    chk("lit_len0_done_once", done_cnt, 1);
    chk("lit_len0_disp", disp_digit, 4'hF);
    // digits 10..14 compared as-is; last digit differs only in bit 3
    mem[0] = 4'd10; mem[1] = 4'd14; mem[2] = 4'd0; mem[3] = 4'd11; mem[4] = 4'd13;
    for (int i = 0; i < 5; i++) keys[i] = mem[i];
    run(5, 5, 1'b0, 0);
    tick();
    keys[4] = 4'd5;
    run(5, 5, 1'b0, 0);
    tick();
    chk("lit_hi_fidx", fail_index, 4'd4);
    // maximum length
    for (int i = 0; i < 15; i++) begin mem[i] = 4'((i * 7 + 2) % 16); keys[i] = mem[i]; end
    run(15, 15, 1'b1, 0);
    tick();
    chk("lit_max_pass", seq_pass, 1'b1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
